aes_decrypt: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher): takes a 128-bit ciphertext block and 128-bit cipher key and produces the plaintext. It is the decrypt counterpart of the team's iterative AES-128 encrypt block and uses the same start/finish handshake, so the same benches and control logic can drive both. Round keys are computed on the fly, not stored. The block expands the key forward to round key 10, then runs the key schedule backward during decryption.

---
 rtl/aes_pkg.sv | 123 ++++++++++++
 rtl/aes_decrypt_if.sv | 11 +
 rtl/aes_key_step.sv | 31 +++
 rtl/aes_decrypt.sv | 98 +++++++++
 tb/tb_aes_decrypt.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-boxes, GF(2^8) arithmetic, round constants and the
// inverse round transforms used inline by the iterative cipher blocks.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} aes_state_e;

    // Each S-box row (high nibble) is held as one 16-byte word, indexed by the low nibble.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[127-8*b[3:0] -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [127:0] row;
        case (b[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[127-8*b[3:0] -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        case (r)
            1:  return 8'h01;
            2:  return 8'h02;
            3:  return 8'h04;
            4:  return 8'h08;
            5:  return 8'h10;
            6:  return 8'h20;
            7:  return 8'h40;
            8:  return 8'h80;
            9:  return 8'h1b;
            10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // State byte i sits at row i%4, column i/4; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = s[127-8*((i % 4) + 4*(((i / 4) + 4 - (i % 4)) % 4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Start/finish handshake bus shared by the iterative AES encrypt and decrypt blocks.
interface aes_decrypt_if;
    logic         start_i;
    logic [127:0] in_i;
    logic [127:0] key_i;
    logic         finish_o;
    logic [127:0] out_o;

    modport master (output start_i, in_i, key_i, input finish_o, out_o);
    modport slave  (input start_i, in_i, key_i, output finish_o, out_o);
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (rk_i -> next round key) or backward
// (rk_i -> previous round key); both directions share one 4-S-box g() path.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [7:0]   rcon_i,
    input  logic         dir_i,
    output logic [127:0] nk_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] g_in, rot, g;
    logic [31:0] f0, f1, f2, f3;

    assign w0 = rk_i[127:96];
    assign w1 = rk_i[95:64];
    assign w2 = rk_i[63:32];
    assign w3 = rk_i[31:0];

    // Backward, the old w3 is recovered first so g() sees the same word as forward.
    assign g_in = dir_i ? (w3 ^ w2) : w3;
    assign rot  = {g_in[23:0], g_in[31:24]};
    assign g    = {sbox(rot[31:24]) ^ rcon_i, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

    assign f0 = w0 ^ g;
    assign f1 = f0 ^ w1;
    assign f2 = f1 ^ w2;
    assign f3 = f2 ^ w3;

    assign nk_o = dir_i ? {w0 ^ g, w1 ^ w0, w2 ^ w1, w3 ^ w2} : {f0, f1, f2, f3};
endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher: 10 cycles of forward key expansion to rk10,
// then 10 inverse rounds walking the key schedule backward.
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    aes_decrypt_if.slave bus
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic         finish_q, finish_d;

    logic [7:0]   rc;
    logic         key_dir;
    logic [127:0] nk;
    logic [127:0] t;

    assign rc      = rcon({28'd0, rnd_q});
    assign key_dir = (state_q == ROUND);

    aes_key_step u_key_step (
        .rk_i   (rk_q),
        .rcon_i (rc),
        .dir_i  (key_dir),
        .nk_o   (nk)
    );

    // In ROUND, nk is the previous round key, so this is the full inverse round minus InvMixColumns.
    assign t = inv_sub_bytes(inv_shift_rows(st_q)) ^ nk;

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        st_d     = st_q;
        rk_d     = rk_q;
        out_d    = out_q;
        finish_d = finish_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    st_d     = bus.in_i;
                    rk_d     = bus.key_i;
                    rnd_d    = 4'd1;
                    finish_d = 1'b0;
                    state_d  = EXPAND;
                end
            end
            EXPAND: begin
                rk_d = nk;
                if (rnd_q == LAST_RND) begin
                    st_d    = st_q ^ nk;
                    rnd_d   = LAST_RND;
                    state_d = ROUND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ROUND: begin
                rk_d  = nk;
                rnd_d = rnd_q - 4'd1;
                st_d  = (rnd_q > 4'd1) ? inv_mix_columns(t) : t;
                if (rnd_q == 4'd1) begin
                    out_d    = t;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rnd_q    <= 4'd0;
            st_q     <= '0;
            rk_q     <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            st_q     <= st_d;
            rk_q     <= rk_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign bus.finish_o = finish_q;
    assign bus.out_o    = out_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 / SP800-38A vectors, handshake timing,
// input isolation, async reset abort and an encrypt/decrypt round trip.
module tb_aes_decrypt;
    import aes_pkg::*;

    logic clk;
    logic rst_n;
    aes_decrypt_if bus();

    aes_decrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    int           lat;
    logic         fin0;
    logic [127:0] rk10;
    logic [127:0] rk_fin;
    logic [127:0] out_pre;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SP_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic [127:0] sp_ct [4];
    logic [127:0] sp_pt [4];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encryptor used only to produce round-trip ciphertexts.
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input int r);
        logic [31:0] rw, g, n0, n1, n2, n3;
        rw = {k[23:0], k[31:24]};
        g  = {sbox(rw[31:24]) ^ rcon(r), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
        n0 = k[127:96] ^ g;
        n1 = n0 ^ k[95:64];
        n2 = n1 ^ k[63:32];
        n3 = n2 ^ k[31:0];
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s, rk, t;
        logic [7:0]   a0, a1, a2, a3;
        s  = p ^ k;
        rk = k;
        for (int r = 1; r <= 10; r++) begin
            rk = key_fwd(rk, r);
            t  = '0;
            for (int i = 0; i < 16; i++)
                t[127-8*i -: 8] = sbox(s[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
            if (r < 10) begin
                s = t;
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    t[127-32*c -: 32] = {
                        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
                end
            end
            s = t ^ rk;
        end
        return s;
    endfunction

    // Accepts one block with start held for `pulse` sampled edges; optionally disturbs
    // in/key and re-pulses start after edge `disturb`. Results land in lat/fin0/rk10/rk_fin/out_pre.
    task automatic run_block(input logic [127:0] k, input logic [127:0] c,
                             input int pulse, input int disturb);
        @(negedge clk);
        bus.key_i   = k;
        bus.in_i    = c;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        fin0        = bus.finish_o;
        bus.start_i = (pulse > 1);
        lat     = 0;
        rk10    = '0;
        rk_fin  = '0;
        out_pre = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            bus.start_i = (e + 1 < pulse);
            if (disturb != 0 && e == disturb) begin
                bus.in_i    = ~c;
                bus.key_i   = ~k;
                bus.start_i = 1'b1;
            end
            if (e == 10) rk10 = dut.rk_q;
            if (e == 19) out_pre = bus.out_o;
            if (bus.finish_o === 1'b1) begin
                lat    = e;
                rk_fin = dut.rk_q;
                break;
            end
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rkey, rpt, rct, held;
        logic         seen_fin;
        n_tests = 0;
        n_fail  = 0;
        sp_ct[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97; sp_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        sp_ct[1] = 128'hf5d3d58503b9699de785895a96fdbaaf; sp_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        sp_ct[2] = 128'h43b1cd7f598ece23881b00e3ed030688; sp_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        sp_ct[3] = 128'h7b0c785e27e8ad3f8223207104725dd4; sp_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;

        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.in_i    = '0;
        bus.key_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_finish", 128'(bus.finish_o), 128'(0));
        check("rst_out", bus.out_o, 128'h0);
        check("rst_state", 128'(dut.state_q), 128'(IDLE));
        check("rst_rnd", 128'(dut.rnd_q), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 C.1
        run_block(C1_KEY, C1_CT, 1, 0);
        check("c1_out", bus.out_o, C1_PT);
        check("c1_lat", 128'(lat), 128'(20));
        check("c1_fin_accept", 128'(fin0), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("c1_hold_out", bus.out_o, C1_PT);
        check("c1_hold_finish", 128'(bus.finish_o), 128'(1));

        // Input isolation: in/key change and start pulse during ROUND
        run_block(C1_KEY, C1_CT, 1, 14);
        check("iso_out", bus.out_o, C1_PT);
        check("iso_lat", 128'(lat), 128'(20));

        // SP800-38A ECB, back-to-back with 2-cycle start pulses
        for (int b = 0; b < 4; b++) begin
            held = bus.out_o;
            run_block(SP_KEY, sp_ct[b], 2, 0);
            check("sp_out", bus.out_o, sp_pt[b]);
            check("sp_lat", 128'(lat), 128'(20));
            check("sp_fin_accept", 128'(fin0), 128'(0));
            check("sp_out_held_busy", out_pre, held);
            if (b == 0) begin
                check("sp_rk10", rk10, SP_RK10);
                check("sp_rk_finish", rk_fin, SP_KEY);
            end
        end

        // Async reset during EXPAND cycle 5
        @(negedge clk);
        bus.key_i   = C1_KEY;
        bus.in_i    = C1_CT;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_finish", 128'(bus.finish_o), 128'(0));
        check("abort_out", bus.out_o, 128'h0);
        check("abort_state", 128'(dut.state_q), 128'(IDLE));
        @(negedge clk);
        rst_n    = 1'b1;
        seen_fin = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.finish_o !== 1'b0) seen_fin = 1'b1;
        end
        check("abort_no_finish", 128'(seen_fin), 128'(0));
        check("abort_out_quiet", bus.out_o, 128'h0);
        run_block(C1_KEY, C1_CT, 1, 0);
        check("post_rst_out", bus.out_o, C1_PT);
        check("post_rst_lat", 128'(lat), 128'(20));

        // Round trip against the reference encryptor
        for (int n = 0; n < 100; n++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rct  = enc(rkey, rpt);
            run_block(rkey, rct, 1, 0);
            check("rt_out", bus.out_o, rpt);
            check("rt_lat", 128'(lat), 128'(20));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
